// File: rtl/pio_poller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_poller_pkg
// Brief    : Shared state encoding, PIO address and width helpers for the
//            switch poller.
// Revision : 1.0
// ============================================================================
package pio_poller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CMP  = 3'd3,
        ST_EMIT = 3'd4
    } poll_state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Bits needed to hold a count from n-1 down to 0 (minimum 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pio_poll_timer.sv
`default_nettype none
// ============================================================================
// Module   : pio_poll_timer
// Brief    : Loadable down-counter; holds at zero and flags terminal count.
// Revision : 1.0
// ============================================================================
module pio_poll_timer #(
    parameter int unsigned     WIDTH  = 16,
    parameter logic [WIDTH-1:0] RELOAD = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RELOAD;
        end else if (i_load) begin
            r_count <= RELOAD;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pio_switch_poller.sv
`default_nettype none
// ============================================================================
// Module   : pio_switch_poller
// Brief    : Avalon-MM master polling a switch PIO and streaming change events.
//            Optional build macro DEBOUNCE_EN requires DEB_POLLS identical
//            samples before a change is reported.
// Revision : 1.0
// ============================================================================
module pio_switch_poller
    import pio_poller_pkg::*;
#(
    parameter int unsigned POLL_DIV   = 50000,
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned DEB_POLLS  = 3
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_value,
    output logic [DATA_W-1:0] evt_changed,
    output logic [DATA_W-1:0] cur_value
);

    localparam int unsigned       c_tmr_w      = cnt_width(POLL_DIV);
    localparam int unsigned       c_lat_w      = cnt_width(RD_LATENCY);
    localparam logic [c_tmr_w-1:0] c_tmr_reload = c_tmr_w'(POLL_DIV - 1);
    localparam logic [c_lat_w-1:0] c_lat_reload = c_lat_w'(RD_LATENCY - 1);

    poll_state_t         r_state;
    logic [c_lat_w-1:0]  r_lat;
    logic [DATA_W-1:0]   r_sample;
    logic [DATA_W-1:0]   r_shadow;
    logic                r_first;
    logic                r_read;
    logic                r_evt_valid;
    logic [DATA_W-1:0]   r_evt_value;
    logic [DATA_W-1:0]   r_evt_changed;
    logic [DATA_W-1:0]   r_cur;

    logic [DATA_W-1:0]   w_diff;
    logic                w_new;
    logic                w_report;
    logic                w_hs;
    logic                w_load;
    logic                w_tc;
    logic                w_rd_unused;

    assign w_diff      = r_sample ^ r_shadow;
    assign w_new       = (w_diff != '0) || r_first;
    assign w_hs        = (r_state == ST_EMIT) && r_evt_valid && evt_ready;
    assign w_load      = ((r_state == ST_CMP) && !w_report) || w_hs;
    assign w_rd_unused = ^avm_readdata;

`ifdef DEBOUNCE_EN
    localparam int unsigned c_run_w = cnt_width(DEB_POLLS + 1);

    logic [c_run_w-1:0] r_run;
    logic [c_run_w-1:0] w_run_next;
    logic [DATA_W-1:0]  r_cand;

    always_comb begin
        w_run_next = c_run_w'(1);
        if ((r_run != '0) && (r_sample == r_cand)) begin
            w_run_next = r_run + c_run_w'(1);
        end
    end

    assign w_report = w_new && (w_run_next >= c_run_w'(DEB_POLLS));

    // A sample matching the reported value breaks any pending run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run  <= '0;
            r_cand <= '0;
        end else if (r_state == ST_CMP) begin
            if (!w_new || w_report) begin
                r_run <= '0;
            end else begin
                r_run <= w_run_next;
            end
            r_cand <= r_sample;
        end
    end
`else
    assign w_report = w_new;
`endif

    pio_poll_timer #(
        .WIDTH  (c_tmr_w),
        .RELOAD (c_tmr_reload)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_en   (r_state == ST_IDLE),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_lat         <= '0;
            r_sample      <= '0;
            r_shadow      <= '0;
            r_first       <= 1'b1;
            r_read        <= 1'b0;
            r_evt_valid   <= 1'b0;
            r_evt_value   <= '0;
            r_evt_changed <= '0;
            r_cur         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tc) begin
                        r_state <= ST_REQ;
                        r_read  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_lat   <= c_lat_reload;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_lat == '0) begin
                        r_sample <= avm_readdata[DATA_W-1:0];
                        r_state  <= ST_CMP;
                    end else begin
                        r_lat <= r_lat - c_lat_w'(1);
                    end
                end
                ST_CMP: begin
                    if (w_report) begin
                        r_state       <= ST_EMIT;
                        r_evt_valid   <= 1'b1;
                        r_evt_value   <= r_sample;
                        r_evt_changed <= r_first ? '1 : w_diff;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (w_hs) begin
                        r_evt_valid <= 1'b0;
                        r_shadow    <= r_evt_value;
                        r_cur       <= r_evt_value;
                        r_first     <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign avm_address = PIO_DATA_ADDR;
    assign avm_read    = r_read;
    assign evt_valid   = r_evt_valid;
    assign evt_value   = r_evt_value;
    assign evt_changed = r_evt_changed;
    assign cur_value   = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_pio_switch_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_switch_poller
// Brief    : Directed bench with an event-prediction model for the poller.
// Revision : 1.0
// ============================================================================
module tb_pio_switch_poller;

    localparam int unsigned POLL_DIV   = 4;
    localparam int unsigned DATA_W     = 10;
    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned DEB_POLLS  = 3;
`ifdef DEBOUNCE_EN
    localparam int c_bound = 60;
`else
    localparam int c_bound = 12;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              evt_valid;
    logic              evt_ready;
    logic [DATA_W-1:0] evt_value;
    logic [DATA_W-1:0] evt_changed;
    logic [DATA_W-1:0] cur_value;
    logic [DATA_W-1:0] sw;

    int checks   = 0;
    int failures = 0;

    pio_switch_poller #(
        .POLL_DIV   (POLL_DIV),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY),
        .DEB_POLLS  (DEB_POLLS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_value       (evt_value),
        .evt_changed     (evt_changed),
        .cur_value       (cur_value)
    );

    always #5 clk = ~clk;

    // PIO slave: registered readdata with junk in the unused upper bits.
    always @(posedge clk) begin
        if (avm_read && !avm_waitrequest) avm_readdata <= {22'h2AAAAA, sw};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: each accepted read yields a sample; the reporting rule decides
    // whether an event appears RD_LATENCY+2 cycles after acceptance.
    typedef struct { logic [DATA_W-1:0] v; logic [DATA_W-1:0] c; } ev_t;
    ev_t               q[$];
    logic [DATA_W-1:0] m_shadow, m_cur, m_cand;
    bit                m_first, m_vexp, acc_prev;
    int                pend, m_run, n_acc;

    always @(negedge clk) begin
        logic [DATA_W-1:0] val;
        bit                rep;
        if (reset) begin
            q.delete();
            m_shadow = '0; m_cur = '0; m_cand = '0;
            m_first = 1; m_vexp = 0; acc_prev = 0; pend = 0; m_run = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) m_vexp = 1;
            end
            check("evt_valid", evt_valid, m_vexp);
            check("cur_value", cur_value, m_cur);
            check("avm_address", avm_address, 0);
            if (m_vexp && q.size() > 0) begin
                check("evt_value", evt_value, q[0].v);
                check("evt_changed", evt_changed, q[0].c);
            end
            if (evt_valid || acc_prev) check("read_idle", avm_read, 0);
            if (m_vexp && evt_valid && evt_ready) begin
                m_cur = q[0].v;
                void'(q.pop_front());
                m_vexp = 0;
            end
            acc_prev = avm_read && !avm_waitrequest;
            if (acc_prev) begin
                n_acc++;
                val = sw;
`ifdef DEBOUNCE_EN
                rep = 0;
                if (!m_first && val == m_shadow) m_run = 0;
                else begin
                    m_run  = (m_run != 0 && val == m_cand) ? m_run + 1 : 1;
                    m_cand = val;
                    rep    = (m_run >= DEB_POLLS);
                    if (rep) m_run = 0;
                end
`else
                rep = m_first || (val != m_shadow);
`endif
                if (rep) begin
                    q.push_back('{v: val, c: m_first ? '1 : (val ^ m_shadow)});
                    m_shadow = val;
                    m_first  = 0;
                    pend     = RD_LATENCY + 2;
                end
            end
        end
    end

    task automatic wait_evt(input string nm, input int lim);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (evt_valid) begin ok = 1; break; end
        end
        check(nm, ok, 1);
    endtask

    task automatic wait_accept(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (avm_read && !avm_waitrequest) begin ok = 1; break; end
        end
        check(nm, ok, 1);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int rise_n, rise_t[3], vcount, acc0;
        bit prev_rd;
        reset = 1; sw = '0; avm_waitrequest = 0; evt_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", evt_valid, 0);
        check("rst_read", avm_read, 0);
        check("rst_value", evt_value, 0);
        check("rst_changed", evt_changed, 0);
        check("rst_cur", cur_value, 0);
        @(posedge clk); #1;
        reset = 0; sw = 10'h005;

        // 1: first report flags every bit
        wait_evt("t1_timeout", c_bound + 30);
        check("t1_value", evt_value, 10'h005);
        check("t1_changed", evt_changed, 10'h3FF);
        @(negedge clk);
        check("t1_cur", cur_value, 10'h005);

        // 2: steady switches, periodic reads, no events
        rise_n = 0; vcount = 0; prev_rd = 0;
        for (int n = 0; n < 40 && rise_n < 3; n++) begin
            @(negedge clk);
            if (evt_valid) vcount++;
            if (avm_read && !prev_rd) begin rise_t[rise_n] = n; rise_n++; end
            prev_rd = avm_read;
        end
        check("t2_rises", rise_n, 3);
        check("t2_period_a", rise_t[1] - rise_t[0], 7);
        check("t2_period_b", rise_t[2] - rise_t[1], 7);
        check("t2_no_evt", vcount, 0);

        // 3: partial change
        @(posedge clk); #1 sw = 10'h305;
        wait_evt("t3_timeout", c_bound);
        check("t3_value", evt_value, 10'h305);
        check("t3_changed", evt_changed, 10'h300);
        @(negedge clk);

        // 4: back-pressure with coalescing
        @(posedge clk); #1 evt_ready = 0; sw = 10'h001;
        wait_evt("t4_timeout", c_bound + 30);
        check("t4_value", evt_value, 10'h001);
        check("t4_changed", evt_changed, 10'h304);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (n == 10) sw = 10'h002;
            @(negedge clk);
            check("t4_stall_read", avm_read, 0);
            check("t4_stall_hold", evt_value, 10'h001);
        end
        @(posedge clk); #1 evt_ready = 1;
        @(negedge clk);
        wait_evt("t4b_timeout", c_bound + 30);
        check("t4b_value", evt_value, 10'h002);
        check("t4b_changed", evt_changed, 10'h003);

        // 5: stalled request
        wait_accept("t5_sync");
        @(posedge clk); #1 avm_waitrequest = 1;
        acc0 = n_acc;
        prev_rd = 0;
        for (int n = 0; n < 20 && !prev_rd; n++) begin
            @(negedge clk);
            prev_rd = avm_read;
        end
        check("t5_req_seen", prev_rd, 1);
        check("t5_addr", avm_address, 0);
        repeat (2) begin
            @(negedge clk);
            check("t5_held", avm_read, 1);
        end
        @(posedge clk); #1 avm_waitrequest = 0;
        @(negedge clk);
        check("t5_held4", avm_read, 1);
        @(negedge clk);
        check("t5_drop", avm_read, 0);
        check("t5_one_sample", n_acc - acc0, 1);

        // 6: reset while the read is in flight
        @(posedge clk); #1 sw = 10'h2A0;
        wait_accept("t6_sync");
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("t6_valid", evt_valid, 0);
        check("t6_read", avm_read, 0);
        check("t6_cur", cur_value, 0);
        wait_evt("t6_timeout", c_bound + 30);
        check("t6_value", evt_value, 10'h2A0);
        check("t6_changed", evt_changed, 10'h3FF);
        @(negedge clk);
`ifdef DEBOUNCE_EN
        @(posedge clk); #1 sw = 10'h0F0;
        wait_accept("t7_sync");
        @(posedge clk); #1 sw = 10'h2A0;
        vcount = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (evt_valid) vcount++;
        end
        check("t7_glitch", vcount, 0);
`endif
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
